// File: rtl/io_input_pkg.sv
// ============================================================================
// Module  : io_input_pkg
// Purpose : Shared constants for the io_input_ctrl register block.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package io_input_pkg;

   localparam int REG_AW = 5;
   localparam int MAX_CH = 32;

   localparam logic [REG_AW-1:0] LEVEL_OFS = 5'h00;
   localparam logic [REG_AW-1:0] PEND_OFS  = 5'h04;
   localparam logic [REG_AW-1:0] RISE_OFS  = 5'h08;
   localparam logic [REG_AW-1:0] FALL_OFS  = 5'h0C;
   localparam logic [REG_AW-1:0] MASK_OFS  = 5'h10;

   // Word index of a byte offset; the two low address bits are don't-care.
   function automatic logic [REG_AW-3:0] word_idx(input logic [REG_AW-1:0] ofs);
      return ofs[REG_AW-1:2];
   endfunction

endpackage

`default_nettype wire

// File: rtl/io_debounce.sv
// ============================================================================
// Module  : io_debounce
// Purpose : Single-channel 2-FF synchroniser, counter debounce, edge pulses.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module io_debounce #(
   parameter int DEBOUNCE_CYC = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_in,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   localparam int            CW      = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

   logic          r_meta;
   logic          r_sync;
   logic          r_level;
   logic          r_rise;
   logic          r_fall;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta  <= 1'b0;
         r_sync  <= 1'b0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_meta <= i_in;
         r_sync <= r_meta;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         if (r_sync == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            // Edge pulses are registered together with the level toggle.
            r_cnt   <= '0;
            r_level <= ~r_level;
            r_rise  <= ~r_level;
            r_fall  <= r_level;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule

`default_nettype wire

// File: rtl/io_input_ctrl.sv
// ============================================================================
// Module  : io_input_ctrl
// Purpose : Debounced input capture with pending/enable registers and IRQ.
//           Optional mask register and o_irq under IO_INPUT_CTRL_IRQ_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module io_input_ctrl
   import io_input_pkg::*;
#(
   parameter int NUM_CH       = 32,
   parameter int DEBOUNCE_CYC = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [NUM_CH-1:0] i_io_in,
   input  logic [REG_AW-1:0] i_addr,
   input  logic              i_wren,
   input  logic [31:0]       i_wdata,
   output logic [31:0]       o_rdata,
   output logic [NUM_CH-1:0] o_level,
   output logic              o_irq
);

   localparam logic [REG_AW-3:0] c_level = word_idx(LEVEL_OFS);
   localparam logic [REG_AW-3:0] c_pend  = word_idx(PEND_OFS);
   localparam logic [REG_AW-3:0] c_rise  = word_idx(RISE_OFS);
   localparam logic [REG_AW-3:0] c_fall  = word_idx(FALL_OFS);
   localparam logic [REG_AW-3:0] c_mask  = word_idx(MASK_OFS);

   logic [NUM_CH-1:0] w_level;
   logic [NUM_CH-1:0] w_rise;
   logic [NUM_CH-1:0] w_fall;
   logic [NUM_CH-1:0] w_set;
   logic [NUM_CH-1:0] w_wd;
   logic [NUM_CH-1:0] w_clr;
   logic [NUM_CH-1:0] w_rd;
   logic [REG_AW-3:0] w_sel;
   logic              w_unused;

   logic [NUM_CH-1:0] r_pend;
   logic [NUM_CH-1:0] r_rise_en;
   logic [NUM_CH-1:0] r_fall_en;

   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
         io_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
         ) u_db (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_in    (i_io_in[g]),
            .o_level (w_level[g]),
            .o_rise  (w_rise[g]),
            .o_fall  (w_fall[g])
         );
      end
   endgenerate

   assign w_sel    = word_idx(i_addr);
   assign w_wd     = i_wdata[NUM_CH-1:0];
   assign w_set    = (w_rise & r_rise_en) | (w_fall & r_fall_en);
   assign w_clr    = (i_wren && (w_sel == c_pend)) ? w_wd : '0;
   assign w_unused = &{1'b0, i_addr[1:0], i_wdata};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pend    <= '0;
         r_rise_en <= '0;
         r_fall_en <= '0;
      end else begin
         // Set has priority over a same-cycle write-1-to-clear.
         r_pend <= (r_pend & ~w_clr) | w_set;
         if (i_wren && (w_sel == c_rise)) r_rise_en <= w_wd;
         if (i_wren && (w_sel == c_fall)) r_fall_en <= w_wd;
      end
   end

`ifdef IO_INPUT_CTRL_IRQ_EN
   logic [NUM_CH-1:0] r_mask;
   logic              r_irq;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mask <= '0;
         r_irq  <= 1'b0;
      end else begin
         r_irq <= |(r_pend & r_mask);
         if (i_wren && (w_sel == c_mask)) r_mask <= w_wd;
      end
   end

   assign o_irq = r_irq;
`else
   assign o_irq = 1'b0;
`endif

   always_comb begin
      w_rd = '0;
      case (w_sel)
         c_level: w_rd = w_level;
         c_pend:  w_rd = r_pend;
         c_rise:  w_rd = r_rise_en;
         c_fall:  w_rd = r_fall_en;
`ifdef IO_INPUT_CTRL_IRQ_EN
         c_mask:  w_rd = r_mask;
`endif
         default: w_rd = '0;
      endcase
   end

   always_comb begin
      o_rdata             = '0;
      o_rdata[NUM_CH-1:0] = w_rd;
   end

   assign o_level = w_level;

endmodule

`default_nettype wire

// File: tb/tb_io_input_ctrl.sv
// ============================================================================
// Module  : tb_io_input_ctrl
// Purpose : Scoreboarded bench for io_input_ctrl (NUM_CH=4, DEBOUNCE_CYC=4).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_io_input_ctrl;

   localparam int NCH = 4;
   localparam int DB  = 4;

   logic           clk;
   logic           rst;
   logic [NCH-1:0] in;
   logic [4:0]     addr;
   logic           wren;
   logic [31:0]    wdata;
   logic [31:0]    rdata;
   logic [NCH-1:0] level;
   logic           irq;

   int total = 0;
   int bad   = 0;

   io_input_ctrl #(
      .NUM_CH       (NCH),
      .DEBOUNCE_CYC (DB)
   ) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_io_in (in),
      .i_addr  (addr),
      .i_wren  (wren),
      .i_wdata (wdata),
      .o_rdata (rdata),
      .o_level (level),
      .o_irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef IO_INPUT_CTRL_IRQ_EN
   localparam bit HAS_IRQ = 1'b1;
`else
   localparam bit HAS_IRQ = 1'b0;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [NCH-1:0] lv;
      logic           irq;
      logic [31:0]    rd;
   } exp_t;

   exp_t exp_q[$];

   bit [NCH-1:0] m_raw1, m_raw2, m_level, m_evr, m_evf;
   bit [NCH-1:0] m_pend, m_ren, m_fen, m_mask;
   bit           m_irq;
   int           m_run [NCH];

   function automatic logic [31:0] m_read(input logic [4:0] a);
      logic [31:0] v;
      v = 32'h0;
      case (a[4:2])
         3'd0: v[NCH-1:0] = m_level;
         3'd1: v[NCH-1:0] = m_pend;
         3'd2: v[NCH-1:0] = m_ren;
         3'd3: v[NCH-1:0] = m_fen;
         3'd4: if (HAS_IRQ) v[NCH-1:0] = m_mask;
         default: v = 32'h0;
      endcase
      return v;
   endfunction

   always begin
      @(posedge clk);
      if (rst) begin
         m_raw1 = '0; m_raw2 = '0; m_level = '0; m_evr = '0; m_evf = '0;
         m_pend = '0; m_ren = '0; m_fen = '0; m_mask = '0; m_irq = 1'b0;
         for (int c = 0; c < NCH; c++) m_run[c] = 0;
      end else begin
         bit [NCH-1:0] wd, clr, set;
         wd    = wdata[NCH-1:0];
         clr   = (wren && addr[4:2] == 3'd1) ? wd : '0;
         set   = (m_evr & m_ren) | (m_evf & m_fen);
         m_irq = HAS_IRQ && ((m_pend & m_mask) != '0);
         m_pend = (m_pend & ~clr) | set;
         if (wren && addr[4:2] == 3'd2) m_ren = wd;
         if (wren && addr[4:2] == 3'd3) m_fen = wd;
         if (wren && addr[4:2] == 3'd4 && HAS_IRQ) m_mask = wd;
         m_evr = '0;
         m_evf = '0;
         // Level follows the synchronised input once it has disagreed DB cycles running.
         for (int c = 0; c < NCH; c++) begin
            if (m_raw2[c] != m_level[c]) begin
               m_run[c]++;
               if (m_run[c] >= DB) begin
                  m_level[c] = ~m_level[c];
                  m_evr[c]   = m_level[c];
                  m_evf[c]   = ~m_level[c];
                  m_run[c]   = 0;
               end
            end else begin
               m_run[c] = 0;
            end
         end
         m_raw2 = m_raw1;
         m_raw1 = in;
      end
      #3;
      exp_q.push_back('{lv: m_level, irq: m_irq, rd: m_read(addr)});
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("level", {28'h0, level}, {28'h0, e.lv});
         chk("irq",   {31'h0, irq},   {31'h0, e.irq});
         chk("rdata", rdata,          e.rd);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      wren  = 1'b1;
      tick();
      wren  = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      chk(nm, rdata, exp);
      tick();
   endtask

   task automatic wait_level(input int ch, input bit val, input string nm);
      int n;
      n = 0;
      while (level[ch] !== val && n < 30) begin
         tick();
         n++;
      end
      if (level[ch] !== val) begin
         total++;
         bad++;
         $display("FAIL %s: level[%0d] timeout, got %b expected %b", nm, ch, level[ch], val);
      end
   endtask

   initial begin
      rst   = 1'b1;
      in    = 4'hF;
      addr  = 5'h0;
      wren  = 1'b0;
      wdata = 32'h0;

      // Reset latency
      wait_n(3);
      chk("rst_level", {28'h0, level}, 32'h0);
      chk("rst_irq",   {31'h0, irq},   32'h0);
      rst = 1'b0;
      wait_n(5);
      chk("rst_lat5", {28'h0, level}, 32'h0);
      tick();
      chk("rst_lat6", {28'h0, level}, 32'hF);
      in = 4'h0;
      wait_n(10);

      // Glitch rejection
      in[0] = 1'b1;
      wait_n(3);
      in[0] = 1'b0;
      wait_n(10);
      rd_chk("glitch_pend", 5'h04, 32'h0);

      // Edge and pend
      wr(5'h08, 32'h3);
      wr(5'h0C, 32'h2);
      in[1] = 1'b1;
      wait_n(9);
      rd_chk("pend_rise1", 5'h04, 32'h2);
      wr(5'h04, 32'h2);
      rd_chk("pend_clr1", 5'h04, 32'h0);
      in[1] = 1'b0;
      wait_n(9);
      rd_chk("pend_fall1", 5'h04, 32'h2);
      wr(5'h04, 32'h2);
      in[2] = 1'b1;
      wait_n(9);
      rd_chk("pend_ch2", 5'h04, 32'h0);

      // Set-vs-clear collision
      in[0] = 1'b1;
      wait_level(0, 1'b1, "coll_wait");
      wr(5'h04, 32'h1);
      rd_chk("collision", 5'h04, 32'h1);

      // IRQ
      wr(5'h04, 32'h1);
      wr(5'h10, 32'h1);
      in[0] = 1'b0;
      wait_n(9);
      in[0] = 1'b1;
      wait_level(0, 1'b1, "irq_wait");
      tick();
      chk("irq_pre", {31'h0, irq}, 32'h0);
      tick();
      chk("irq_set", {31'h0, irq}, {31'h0, HAS_IRQ});
      wr(5'h04, 32'h1);
      chk("irq_hold", {31'h0, irq}, {31'h0, HAS_IRQ});
      tick();
      chk("irq_drop", {31'h0, irq}, 32'h0);
      wr(5'h08, 32'h9);
      in[3] = 1'b1;
      wait_n(9);
      rd_chk("pend_ch3", 5'h04, 32'h8);
      chk("irq_unmasked", {31'h0, irq}, 32'h0);
      wr(5'h04, 32'h8);
      wr(5'h08, 32'h3);

      // Address decode
      wr(5'h00, 32'hFFFF_FFFF);
      wr(5'h14, 32'hFFFF_FFFF);
      rd_chk("rd_14", 5'h14, 32'h0);
      rd_chk("rd_1c", 5'h1C, 32'h0);
      rd_chk("rd_08", 5'h08, 32'h3);
      rd_chk("rd_0b", 5'h0B, 32'h3);
      rd_chk("rd_10", 5'h10, HAS_IRQ ? 32'h1 : 32'h0);

      // Randomized phase, checked by the scoreboard every cycle
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < NCH; c++)
            if ($urandom_range(0, 5) == 0) in[c] = ~in[c];
         rst   = ($urandom_range(0, 599) == 0);
         wren  = ($urandom_range(0, 5) == 0);
         addr  = 5'($urandom_range(0, 31));
         wdata = $urandom;
         tick();
      end
      rst  = 1'b0;
      wren = 1'b0;
      wait_n(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
